risc_v_processor_3: RTL and testbench
=====================================

RISC_V_PROCESSOR_3 -- requirements
Module: risc_v_processor_3

Interface
REQ-001 Parameter IMEM_WORDS, default 256: instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 256: data memory depth in 32-bit words.
REQ-003 Parameter IMEM_FILE, default "program.mem": hex image loaded into instruction memory at time zero.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 No other ports; the core is self-contained and observed hierarchically by the bench.

Function
REQ-007 Single-cycle RV32I subset; one instruction completes per clock; PC, register file and data memory update on the same rising edge.
REQ-008 Supported R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SLT (signed).
REQ-009 Supported I-type: ADDI, ANDI, ORI, XORI, SLLI, SRLI, SLTI; immediate sign-extended from 12 bits; shift amount is bits [4:0].
REQ-010 Supported memory ops: LW, SW only; effective address = rs1 + sign-extended imm.
REQ-011 Supported control flow: BEQ, BNE, BLT (signed), BGE (signed), JAL, JALR; branch/JAL target = PC + sign-extended imm (bit 0 = 0); JALR target = (rs1 + imm) with bit 0 cleared; JAL/JALR write PC+4 to rd.
REQ-012 Non-taken branches and all other instructions: next PC = PC + 4; PC is 32 bits and wraps modulo 2^32.
REQ-013 Any unsupported opcode executes as a NOP: no register or memory write, PC + 4.
REQ-014 Instruction fetch: combinational, word index = PC[log2(IMEM_WORDS)+1:2]; upper PC bits ignored (address wraps within memory).
REQ-015 Data memory: combinational read, synchronous write on rising edge when SW executes; word index = address[log2(DMEM_WORDS)+1:2]; address bits [1:0] ignored (no misalignment trap); out-of-range addresses wrap.
REQ-016 Register file: 32 x 32-bit, two combinational read ports, one write port on rising edge; x0 reads 0 always and writes to x0 are discarded.
REQ-017 Read-during-write of the same register in one cycle returns the old value (write lands at the edge).
REQ-018 ALU arithmetic is 32-bit two's complement; overflow wraps silently; no flags beyond zero/less-than used for branches.

Reset
REQ-019 While reset is high at a rising edge: PC <= 0, all 32 registers <= 0, no data memory write occurs.
REQ-020 Data memory contents are not cleared by reset; instruction memory is read-only and retains its image.
REQ-021 First instruction executed is at PC 0 on the first rising edge after reset deasserts; reset asserted mid-program restarts at PC 0 on the next edge.

Structure
REQ-022 Shared package riscv_pkg holds opcode constants, funct3/funct7 codes, ALU-operation enum and the XLEN=32 constant.
REQ-023 One sub-module regfile (instance name u_regfile, array regs[0:31]); instruction and data memories are arrays imem and dmem inside the top level for hierarchical inspection; PC register named pc.
REQ-024 Decode, immediate generation, ALU and next-PC logic are combinational blocks in the top level.

Verification
REQ-025 Reset: hold reset 1 cycle with pc=0x40 preloaded -> pc=0, all regs 0 after the edge; no dmem change.
REQ-026 Arithmetic: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SLT x5,x2,x1 -> x3=2, x4=0xFFFFFFF8, x5=1 after 5 cycles.
REQ-027 Memory: ADDI x1,x0,0x123; SW x1,8(x0); LW x6,8(x0) -> dmem[2]=0x123, x6=0x123.
REQ-028 Loop/branch: x1=0, x2=10; loop ADDI x1,x1,1; BNE x1,x2,-4 -> exits with x1=10 after 2+20 cycles, pc = loop end + 4.
REQ-029 x0 and jump: ADDI x0,x0,7; JAL x7,+8 at PC 0x10 -> x0=0, x7=0x14, next pc=0x18; illegal opcode 0x0000007F executes as NOP (pc+4, no writes).
REQ-030 Run 3100 cycles of a bubble-sort program over 8 words in dmem -> dmem holds ascending values, no X on pc.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the risc_v_processor_3 core.
// Holds the XLEN constant, RV32I opcode / funct3 / funct7 codes used by the
// supported subset, the ALU operation enum, the write-back select enum and a
// helper that maps funct3/funct7 onto an ALU operation (or flags the
// combination as unsupported so the instruction degrades to a NOP).
package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Memory / jump funct3
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_JALR    = 3'b000;

    // Branch funct3
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;

    // funct7
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } alu_dec_t;

    // Maps an OP / OP-IMM encoding to an ALU operation. For OP-IMM only the
    // shift forms look at funct7 (it is imm[11:5] there). Encodings outside
    // the subset (SLTU, SRA, SRAI, ...) come back with valid = 0.
    function automatic alu_dec_t decode_alu(input logic [2:0] funct3,
                                            input logic [6:0] funct7,
                                            input logic       is_reg);
        alu_dec_t d;
        d.valid = 1'b0;
        d.op    = ALU_ADD;
        case (funct3)
            F3_ADD_SUB: begin
                if (!is_reg || funct7 == F7_BASE) begin
                    d.valid = 1'b1;
                    d.op    = ALU_ADD;
                end else if (funct7 == F7_ALT) begin
                    d.valid = 1'b1;
                    d.op    = ALU_SUB;
                end
            end
            F3_SLL: begin
                d.valid = (funct7 == F7_BASE);
                d.op    = ALU_SLL;
            end
            F3_SR: begin
                d.valid = (funct7 == F7_BASE);
                d.op    = ALU_SRL;
            end
            F3_SLT: begin
                d.valid = !is_reg || funct7 == F7_BASE;
                d.op    = ALU_SLT;
            end
            F3_XOR: begin
                d.valid = !is_reg || funct7 == F7_BASE;
                d.op    = ALU_XOR;
            end
            F3_OR: begin
                d.valid = !is_reg || funct7 == F7_BASE;
                d.op    = ALU_OR;
            end
            F3_AND: begin
                d.valid = !is_reg || funct7 == F7_BASE;
                d.op    = ALU_AND;
            end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/risc_v_processor_3_if.sv
// Register-file access bus between the core datapath and the regfile.
// master (datapath): drives read addresses and the single write port.
// slave  (regfile) : returns the two combinational read values.
interface risc_v_processor_3_if;
    import riscv_pkg::*;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data,
        output rs1_data, rs2_data
    );
endinterface

// File: rtl/risc_v_processor_3_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port.
// Ports:
//   i_clk   - clock, write lands on the rising edge
//   i_reset - synchronous active-high reset, clears every register
//   rf      - register bus (slave side)
// x0 is hard-wired to zero on read and never written. A read of a register
// being written in the same cycle returns the old value, since the write
// only lands at the edge.
module regfile
    import riscv_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    risc_v_processor_3_if.slave  rf
);

    logic [XLEN-1:0] regs [0:31];

    always_ff @(posedge i_clk) begin
        regs[0] <= '0;
    end

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    regs[gi] <= '0;
                end else if (rf.we && rf.rd_addr == 5'(gi)) begin
                    regs[gi] <= rf.rd_data;
                end
            end
        end
    endgenerate

    assign rf.rs1_data = (rf.rs1_addr == 5'd0) ? '0 : regs[rf.rs1_addr];
    assign rf.rs2_data = (rf.rs2_addr == 5'd0) ? '0 : regs[rf.rs2_addr];

endmodule

// File: rtl/risc_v_processor_3.sv
// Single-cycle RV32I-subset core with internal instruction and data memory.
// Ports:
//   clk   - single clock; PC, registers and data memory update on rising edge
//   reset - synchronous active-high; PC and registers cleared, no store
// Parameters:
//   IMEM_WORDS / DMEM_WORDS - memory depths in 32-bit words (powers of two)
//   IMEM_FILE               - name of the instruction image
// State is observed hierarchically: pc, imem, dmem, u_regfile.regs.
module risc_v_processor_3
    import riscv_pkg::*;
#(
    parameter int    IMEM_WORDS = 256,
    parameter int    DMEM_WORDS = 256,
    parameter string IMEM_FILE  = "program.mem"
) (
    input  logic clk,
    input  logic reset
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    logic [XLEN-1:0] imem [0:IMEM_WORDS-1];
    logic [XLEN-1:0] dmem [0:DMEM_WORDS-1];
    logic [XLEN-1:0] pc;

    risc_v_processor_3_if rf_bus ();

    regfile u_regfile (
        .i_clk   (clk),
        .i_reset (reset),
        .rf      (rf_bus)
    );

    // ---------------- fetch / field extraction ----------------
    logic [XLEN-1:0] w_instr;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;

    assign w_instr  = imem[pc[IMEM_AW+1:2]];
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_funct7 = w_instr[31:25];

    // ---------------- immediate generation ----------------
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;

    always_comb begin
        w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
        w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                   w_instr[30:25], w_instr[11:8], 1'b0};
        w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                   w_instr[20], w_instr[30:21], 1'b0};
    end

    // ---------------- decode ----------------
    alu_dec_t        w_alu_dec;
    alu_op_e         w_alu_op;
    wb_sel_e         w_wb_sel;
    logic            w_reg_we;
    logic            w_mem_we;
    logic            w_use_imm;
    logic [XLEN-1:0] w_imm_sel;
    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;

    assign w_alu_dec = decode_alu(w_funct3, w_funct7, w_opcode == OPC_OP);

    // Anything not explicitly recognised keeps every enable low, which is
    // exactly the NOP behaviour (PC + 4, no writes).
    always_comb begin
        w_alu_op    = ALU_ADD;
        w_wb_sel    = WB_ALU;
        w_reg_we    = 1'b0;
        w_mem_we    = 1'b0;
        w_use_imm   = 1'b0;
        w_imm_sel   = w_imm_i;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_reg_we = w_alu_dec.valid;
                w_alu_op = w_alu_dec.op;
            end
            OPC_OP_IMM: begin
                w_reg_we  = w_alu_dec.valid;
                w_alu_op  = w_alu_dec.op;
                w_use_imm = 1'b1;
            end
            OPC_LOAD: begin
                w_reg_we  = (w_funct3 == F3_WORD);
                w_wb_sel  = WB_MEM;
                w_use_imm = 1'b1;
            end
            OPC_STORE: begin
                w_mem_we  = (w_funct3 == F3_WORD);
                w_use_imm = 1'b1;
                w_imm_sel = w_imm_s;
            end
            OPC_BRANCH: begin
                w_is_branch = (w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE) ||
                              (w_funct3 == F3_BLT) || (w_funct3 == F3_BGE);
            end
            OPC_JAL: begin
                w_reg_we = 1'b1;
                w_wb_sel = WB_PC4;
                w_is_jal = 1'b1;
            end
            OPC_JALR: begin
                w_reg_we  = (w_funct3 == F3_JALR);
                w_wb_sel  = WB_PC4;
                w_use_imm = 1'b1;
                w_is_jalr = (w_funct3 == F3_JALR);
            end
            default: ;
        endcase
    end

    // ---------------- register read ----------------
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign rf_bus.rs1_addr = w_rs1;
    assign rf_bus.rs2_addr = w_rs2;
    assign w_rs1_data      = rf_bus.rs1_data;
    assign w_rs2_data      = rf_bus.rs2_data;

    // ---------------- ALU ----------------
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_result;

    assign w_alu_b = w_use_imm ? w_imm_sel : w_rs2_data;

    always_comb begin
        w_alu_result = '0;
        case (w_alu_op)
            ALU_ADD: w_alu_result = w_rs1_data + w_alu_b;
            ALU_SUB: w_alu_result = w_rs1_data - w_alu_b;
            ALU_AND: w_alu_result = w_rs1_data & w_alu_b;
            ALU_OR:  w_alu_result = w_rs1_data | w_alu_b;
            ALU_XOR: w_alu_result = w_rs1_data ^ w_alu_b;
            ALU_SLL: w_alu_result = w_rs1_data << w_alu_b[4:0];
            ALU_SRL: w_alu_result = w_rs1_data >> w_alu_b[4:0];
            ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}},
                                     $signed(w_rs1_data) < $signed(w_alu_b)};
            default: w_alu_result = '0;
        endcase
    end

    // ---------------- branch compare / next PC ----------------
    logic            w_take_branch;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;

    always_comb begin
        w_take_branch = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_take_branch = (w_rs1_data == w_rs2_data);
            F3_BNE:  w_take_branch = (w_rs1_data != w_rs2_data);
            F3_BLT:  w_take_branch = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            F3_BGE:  w_take_branch = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            default: w_take_branch = 1'b0;
        endcase
    end

    assign w_pc_plus4 = pc + 32'd4;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_is_jal) begin
            w_pc_next = pc + w_imm_j;
        end else if (w_is_jalr) begin
            // JALR target comes out of the ALU (rs1 + imm) with bit 0 cleared.
            w_pc_next = {w_alu_result[XLEN-1:1], 1'b0};
        end else if (w_is_branch && w_take_branch) begin
            w_pc_next = pc + w_imm_b;
        end
    end

    // ---------------- data memory / write back ----------------
    logic [DMEM_AW-1:0] w_dmem_idx;
    logic [XLEN-1:0]    w_mem_rdata;
    logic [XLEN-1:0]    w_wb_data;

    assign w_dmem_idx  = w_alu_result[DMEM_AW+1:2];
    assign w_mem_rdata = dmem[w_dmem_idx];

    always_comb begin
        w_wb_data = w_alu_result;
        case (w_wb_sel)
            WB_MEM:  w_wb_data = w_mem_rdata;
            WB_PC4:  w_wb_data = w_pc_plus4;
            default: w_wb_data = w_alu_result;
        endcase
    end

    assign rf_bus.we      = w_reg_we;
    assign rf_bus.rd_addr = w_rd;
    assign rf_bus.rd_data = w_wb_data;

    // Data memory is not cleared by reset; reset only blocks the store.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            dmem[w_dmem_idx] <= w_rs2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= w_pc_next;
        end
    end

endmodule

// File: tb/tb_risc_v_processor_3.sv
// Directed bench for risc_v_processor_3: loads small hand-assembled programs
// into dut.imem, runs a fixed number of cycles and checks hierarchical state
// against hand-computed values.
module tb_risc_v_processor_3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    risc_v_processor_3 #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .IMEM_FILE  ("")
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    localparam logic [31:0] OPI  = 32'h13;
    localparam logic [31:0] OPL  = 32'h03;
    localparam logic [31:0] OPJR = 32'h67;
    localparam logic [31:0] NOP  = 32'h00000013;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.imem[i] = NOP;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rf(input int i);
        return dut.u_regfile.regs[i];
    endfunction

    function automatic logic [31:0] nonzero_regs();
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) if (dut.u_regfile.regs[i] !== 32'd0) n++;
        return 32'(n);
    endfunction

    logic [31:0] snap [0:7];
    logic [31:0] snap4;
    int          dmem_diff;
    int          sort_vals [0:7];
    int          sort_exp  [0:7];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;

        // ---------- arithmetic program ----------
        clear_imem();
        dut.imem[0] = enc_i(5, 0, 0, 1, OPI);              // ADDI x1,x0,5
        dut.imem[1] = enc_i(-3, 0, 0, 2, OPI);             // ADDI x2,x0,-3
        dut.imem[2] = enc_r(0, 2, 1, 0, 3);                // ADD x3,x1,x2
        dut.imem[3] = enc_r(32'h20, 1, 2, 0, 4);           // SUB x4,x2,x1
        dut.imem[4] = enc_r(0, 1, 2, 2, 5);                // SLT x5,x2,x1
        do_reset();
        check("reset_pc", dut.pc, 32'h0);
        check("reset_regs_nonzero", nonzero_regs(), 32'd0);
        run(5);
        check("arith_x1", rf(1), 32'd5);
        check("arith_x3", rf(3), 32'd2);
        check("arith_x4", rf(4), 32'hFFFFFFF8);
        check("arith_x5", rf(5), 32'd1);
        check("arith_pc", dut.pc, 32'h14);

        // ---------- reset from pc=0x40 ----------
        run(11);
        check("pre_reset_pc", dut.pc, 32'h40);
        for (int i = 0; i < 8; i++) snap[i] = dut.dmem[i];
        do_reset();
        check("rst40_pc", dut.pc, 32'h0);
        check("rst40_regs_nonzero", nonzero_regs(), 32'd0);
        dmem_diff = 0;
        for (int i = 0; i < 8; i++) if (dut.dmem[i] !== snap[i]) dmem_diff++;
        check("rst40_dmem_changed", 32'(dmem_diff), 32'd0);

        // ---------- memory program ----------
        clear_imem();
        dut.imem[0] = enc_i(32'h123, 0, 0, 1, OPI);        // ADDI x1,x0,0x123
        dut.imem[1] = enc_s(8, 1, 0);                      // SW x1,8(x0)
        dut.imem[2] = enc_i(8, 0, 2, 6, OPL);              // LW x6,8(x0)
        dut.imem[3] = enc_s(16, 1, 0);                     // SW x1,16(x0)
        do_reset();
        run(3);
        check("mem_dmem2", dut.dmem[2], 32'h123);
        check("mem_x6", rf(6), 32'h123);
        // Reset edge lands while SW x1,16(x0) is the current instruction.
        snap4 = dut.dmem[4];
        do_reset();
        check("mem_sw_blocked_by_reset", dut.dmem[4], snap4);
        check("mem_rst_x1", rf(1), 32'h0);

        // ---------- logic / shift program ----------
        clear_imem();
        dut.imem[0]  = enc_i(32'h5A5, 0, 0, 1, OPI);       // ADDI x1,x0,0x5A5
        dut.imem[1]  = enc_i(-16, 0, 0, 2, OPI);           // ADDI x2,x0,-16
        dut.imem[2]  = enc_r(0, 2, 1, 7, 3);               // AND x3,x1,x2
        dut.imem[3]  = enc_r(0, 2, 1, 6, 4);               // OR  x4,x1,x2
        dut.imem[4]  = enc_r(0, 2, 1, 4, 5);               // XOR x5,x1,x2
        dut.imem[5]  = enc_i(4, 1, 1, 6, OPI);             // SLLI x6,x1,4
        dut.imem[6]  = enc_i(28, 2, 5, 7, OPI);            // SRLI x7,x2,28
        dut.imem[7]  = enc_i(-15, 2, 2, 8, OPI);           // SLTI x8,x2,-15
        dut.imem[8]  = enc_i(32'hFF, 2, 7, 9, OPI);        // ANDI x9,x2,0xFF
        dut.imem[9]  = enc_i(-1, 0, 6, 10, OPI);           // ORI x10,x0,-1
        dut.imem[10] = enc_i(32'hF0, 1, 4, 11, OPI);       // XORI x11,x1,0xF0
        dut.imem[11] = enc_r(0, 7, 1, 1, 12);              // SLL x12,x1,x7
        dut.imem[12] = enc_r(0, 7, 2, 5, 13);              // SRL x13,x2,x7
        dut.imem[13] = enc_r(0, 2, 1, 2, 14);              // SLT x14,x1,x2
        do_reset();
        run(14);
        check("logic_and",  rf(3),  32'h000005A0);
        check("logic_or",   rf(4),  32'hFFFFFFF5);
        check("logic_xor",  rf(5),  32'hFFFFFA55);
        check("logic_slli", rf(6),  32'h00005A50);
        check("logic_srli", rf(7),  32'h0000000F);
        check("logic_slti", rf(8),  32'd1);
        check("logic_andi", rf(9),  32'h000000F0);
        check("logic_ori",  rf(10), 32'hFFFFFFFF);
        check("logic_xori", rf(11), 32'h00000555);
        check("logic_sll",  rf(12), 32'h02D28000);
        check("logic_srl",  rf(13), 32'h0001FFFF);
        check("logic_slt",  rf(14), 32'd0);

        // ---------- loop / branch ----------
        clear_imem();
        dut.imem[0] = enc_i(0, 0, 0, 1, OPI);              // ADDI x1,x0,0
        dut.imem[1] = enc_i(10, 0, 0, 2, OPI);             // ADDI x2,x0,10
        dut.imem[2] = enc_i(1, 1, 0, 1, OPI);              // loop: ADDI x1,x1,1
        dut.imem[3] = enc_b(-4, 2, 1, 1);                  // BNE x1,x2,-4
        do_reset();
        run(21);
        check("loop_x1_last_add", rf(1), 32'd10);
        check("loop_pc_at_bne", dut.pc, 32'h0C);
        run(1);
        check("loop_exit_pc", dut.pc, 32'h10);
        check("loop_x1", rf(1), 32'd10);

        // ---------- x0, JAL, illegal opcode, JALR ----------
        clear_imem();
        dut.imem[3] = enc_i(7, 0, 0, 0, OPI);              // 0x0C ADDI x0,x0,7
        dut.imem[4] = enc_j(8, 7);                         // 0x10 JAL x7,+8
        dut.imem[6] = 32'h0000007F;                        // 0x18 illegal
        dut.imem[7] = enc_i(9, 7, 0, 8, OPJR);             // 0x1C JALR x8,9(x7)
        do_reset();
        run(4);
        check("x0_stays_zero", rf(0), 32'd0);
        check("jal_pc_before", dut.pc, 32'h10);
        run(1);
        check("jal_x7", rf(7), 32'h14);
        check("jal_pc", dut.pc, 32'h18);
        run(1);
        check("illegal_pc", dut.pc, 32'h1C);
        check("illegal_regs_nonzero", nonzero_regs(), 32'd1);
        run(1);
        check("jalr_pc", dut.pc, 32'h1C);
        check("jalr_x8", rf(8), 32'h20);

        // ---------- bubble sort ----------
        sort_vals = '{5, -1, 12, 0, 7, -8, 3, 2};
        sort_exp  = '{-8, -1, 0, 2, 3, 5, 7, 12};
        clear_imem();
        for (int i = 0; i < 8; i++) begin
            dut.imem[2*i]   = enc_i(32'(sort_vals[i]), 0, 0, 1, OPI);  // ADDI x1,x0,v
            dut.imem[2*i+1] = enc_s(32'(4*i), 1, 0);                   // SW x1,4i(x0)
        end
        dut.imem[16] = enc_i(7, 0, 0, 10, OPI);            // 0x40 ADDI x10,x0,7
        dut.imem[17] = enc_i(0, 0, 0, 11, OPI);            // 0x44 ADDI x11,x0,0
        dut.imem[18] = enc_i(2, 10, 1, 13, OPI);           // 0x48 SLLI x13,x10,2
        dut.imem[19] = enc_i(0, 11, 2, 14, OPL);           // 0x4C LW x14,0(x11)
        dut.imem[20] = enc_i(4, 11, 2, 15, OPL);           // 0x50 LW x15,4(x11)
        dut.imem[21] = enc_b(12, 14, 15, 5);               // 0x54 BGE x15,x14,+12
        dut.imem[22] = enc_s(0, 15, 11);                   // 0x58 SW x15,0(x11)
        dut.imem[23] = enc_s(4, 14, 11);                   // 0x5C SW x14,4(x11)
        dut.imem[24] = enc_i(4, 11, 0, 11, OPI);           // 0x60 ADDI x11,x11,4
        dut.imem[25] = enc_b(-24, 13, 11, 1);              // 0x64 BNE x11,x13,-24
        dut.imem[26] = enc_i(-1, 10, 0, 10, OPI);          // 0x68 ADDI x10,x10,-1
        dut.imem[27] = enc_b(-40, 0, 10, 1);               // 0x6C BNE x10,x0,-40
        dut.imem[28] = enc_j(0, 0);                        // 0x70 JAL x0,0
        do_reset();
        run(3100);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sort_dmem%0d", i), dut.dmem[i], 32'(sort_exp[i]));
        end
        check("sort_pc_known", 32'($isunknown(dut.pc)), 32'd0);
        check("sort_halt_pc", dut.pc, 32'h70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
